// File: rtl/vend_pkg.sv
// Shared state type and helpers for the multi-product vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE
  } vend_state_e;

  localparam int PRICE_VEC_W = 64;

  function automatic int max_coin(input int coin_w);
    return (1 << coin_w) - 1;
  endfunction

  // Extracts product idx's price from a packed table whose entry 0 sits in the LSBs.
  function automatic logic [15:0] price_slice(input logic [PRICE_VEC_W-1:0] prices,
                                              input int unsigned idx,
                                              input int unsigned w);
    logic [PRICE_VEC_W-1:0] shifted;
    shifted = prices >> (idx * w);
    return shifted[15:0] & ((16'd1 << w) - 16'd1);
  endfunction

endpackage

// File: rtl/vend_multi_fsm_if.sv
// Coin/selection inputs and actuator/status outputs of the vending controller.
interface vend_multi_fsm_if #(
  parameter int SEL_W    = 2,
  parameter int COIN_W   = 2,
  parameter int CREDIT_W = 5
);

  logic [COIN_W-1:0]   coin_in;
  logic                coin_inserted;
  logic [SEL_W-1:0]    product_sel;
  logic                select_valid;
  logic                cancel;
  logic                dispense;
  logic [SEL_W-1:0]    dispense_id;
  logic                change_valid;
  logic [COIN_W-1:0]   change_coin;
  logic                coin_reject;
  logic                sel_error;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output coin_in, coin_inserted, product_sel, select_valid, cancel,
    input  dispense, dispense_id, change_valid, change_coin, coin_reject,
           sel_error, credit, busy
  );

  modport slave (
    input  coin_in, coin_inserted, product_sel, select_valid, cancel,
    output dispense, dispense_id, change_valid, change_coin, coin_reject,
           sel_error, credit, busy
  );

endinterface

// File: rtl/vend_change_unit.sv
// Picks the largest coin not exceeding the amount still owed and the amount left afterwards.
module vend_change_unit
  import vend_pkg::*;
#(
  parameter int COIN_W   = 2,
  parameter int CREDIT_W = 5
) (
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [COIN_W-1:0]   o_coin,
  output logic [CREDIT_W-1:0] o_remain
);

  localparam logic [CREDIT_W-1:0] MAX_COIN = CREDIT_W'(max_coin(COIN_W));

  logic [CREDIT_W-1:0] w_coin;

  assign w_coin   = (i_credit > MAX_COIN) ? MAX_COIN : i_credit;
  assign o_coin   = w_coin[COIN_W-1:0];
  assign o_remain = i_credit - w_coin;

endmodule

// File: rtl/vend_multi_fsm.sv
// Multi-product vending controller: credit collection, price check, vend pulse, serial change payout.
module vend_multi_fsm
  import vend_pkg::*;
#(
  parameter int NUM_PRODUCTS = 4,
  parameter int SEL_W        = 2,
  parameter int COIN_W       = 2,
  parameter int CREDIT_W     = 5,
  parameter int MAX_CREDIT   = 20,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = {5'd9, 5'd8, 5'd7, 5'd5}
) (
  input logic             clk,
  input logic             reset,
  vend_multi_fsm_if.slave io_vend
);

  localparam logic [PRICE_VEC_W-1:0] PRICE_VEC = PRICE_VEC_W'(PRICES);
  localparam logic [CREDIT_W:0]      CEILING   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [SEL_W:0]         NUM_SEL   = (SEL_W+1)'(NUM_PRODUCTS);

  vend_state_e         r_state, w_state_next;
  logic [CREDIT_W-1:0] r_credit, w_credit_next, w_pay, w_remain, w_sel_price, w_vend_price;
  logic [SEL_W-1:0]    r_sel, w_sel_next, r_dispense_id;
  logic [CREDIT_W:0]   w_sum;
  logic [COIN_W-1:0]   w_change, r_change_coin;
  logic                w_coin_evt, w_sel_bad, w_reject, w_sel_err;
  logic                r_dispense, r_change_valid, r_coin_reject, r_sel_error, r_busy;

  assign w_coin_evt   = io_vend.coin_inserted && (io_vend.coin_in != '0);
  assign w_sum        = {1'b0, r_credit} + (CREDIT_W+1)'(io_vend.coin_in);
  assign w_sel_price  = CREDIT_W'(price_slice(PRICE_VEC, 32'(io_vend.product_sel), CREDIT_W));
  assign w_vend_price = CREDIT_W'(price_slice(PRICE_VEC, 32'(r_sel), CREDIT_W));
  assign w_sel_bad    = ({1'b0, io_vend.product_sel} >= NUM_SEL) || (r_credit < w_sel_price);

  // Amount still owed to the customer: after the vend this is credit minus price.
  assign w_pay = (r_state == VEND) ? (r_credit - w_vend_price) : r_credit;

  vend_change_unit #(
    .COIN_W   (COIN_W),
    .CREDIT_W (CREDIT_W)
  ) u_change (
    .i_credit (w_pay),
    .o_coin   (w_change),
    .o_remain (w_remain)
  );

  always_comb begin
    w_state_next  = r_state;
    w_credit_next = r_credit;
    w_sel_next    = r_sel;
    w_reject      = 1'b0;
    w_sel_err     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (io_vend.cancel) begin
          w_reject = w_coin_evt;
        end else if (io_vend.select_valid) begin
          w_reject  = w_coin_evt;
          w_sel_err = 1'b1;
        end else if (w_coin_evt) begin
          w_credit_next = CREDIT_W'(io_vend.coin_in);
          w_state_next  = COLLECT;
        end
      end
      COLLECT: begin
        if (io_vend.cancel) begin
          w_reject      = w_coin_evt;
          w_credit_next = w_remain;
          w_state_next  = (w_pay != '0) ? CHANGE : IDLE;
        end else if (io_vend.select_valid) begin
          w_reject = w_coin_evt;
          if (w_sel_bad) begin
            w_sel_err = 1'b1;
          end else begin
            w_sel_next   = io_vend.product_sel;
            w_state_next = VEND;
          end
        end else if (w_coin_evt) begin
          if (w_sum <= CEILING) w_credit_next = w_sum[CREDIT_W-1:0];
          else                  w_reject      = 1'b1;
        end
      end
      // Credit shown during payout is what is still owed after the coin on the outputs.
      VEND, CHANGE: begin
        w_reject      = w_coin_evt;
        w_credit_next = w_remain;
        w_state_next  = (w_pay != '0) ? CHANGE : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_credit       <= '0;
      r_sel          <= '0;
      r_dispense     <= 1'b0;
      r_dispense_id  <= '0;
      r_change_valid <= 1'b0;
      r_change_coin  <= '0;
      r_coin_reject  <= 1'b0;
      r_sel_error    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_credit       <= w_credit_next;
      r_sel          <= w_sel_next;
      r_dispense     <= (w_state_next == VEND);
      r_dispense_id  <= (w_state_next == VEND) ? w_sel_next : '0;
      r_change_valid <= (w_state_next == CHANGE);
      r_change_coin  <= (w_state_next == CHANGE) ? w_change : '0;
      r_coin_reject  <= w_reject;
      r_sel_error    <= w_sel_err;
      r_busy         <= (w_state_next == VEND) || (w_state_next == CHANGE);
    end
  end

  assign io_vend.dispense     = r_dispense;
  assign io_vend.dispense_id  = r_dispense_id;
  assign io_vend.change_valid = r_change_valid;
  assign io_vend.change_coin  = r_change_coin;
  assign io_vend.coin_reject  = r_coin_reject;
  assign io_vend.sel_error    = r_sel_error;
  assign io_vend.credit       = r_credit;
  assign io_vend.busy         = r_busy;

endmodule

// File: tb/tb_vend_multi_fsm.sv
// Bench for vend_multi_fsm: directed vector table, async-reset sequence, then random traffic vs a model.
module tb_vend_multi_fsm;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  vend_multi_fsm_if #(.SEL_W(2), .COIN_W(2), .CREDIT_W(5)) tb_if ();

  vend_multi_fsm #(
    .NUM_PRODUCTS (4),
    .SEL_W        (2),
    .COIN_W       (2),
    .CREDIT_W     (5),
    .MAX_CREDIT   (20),
    .PRICES       ({5'd9, 5'd8, 5'd7, 5'd5})
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .io_vend (tb_if)
  );

  typedef struct {
    bit         ci;
    logic [1:0] coin;
    bit         sv;
    logic [1:0] sel;
    bit         can;
    logic [13:0] exp;
  } vec_t;

  typedef struct {
    bit         d;
    logic [1:0] id;
    bit         cv;
    logic [1:0] cc;
    int         credit;
  } step_t;

  int          checks = 0;
  int          errors = 0;
  int          prices [4] = '{5, 7, 8, 9};
  int          m_credit;
  bit          m_busy;
  step_t       m_q[$];
  logic [13:0] m_exp;
  vec_t        tbl[$];

  // Output vector layout: dispense, id[2], change_valid, coin[2], reject, sel_error, credit[5], busy.
  function automatic logic [13:0] pack_out(bit d, logic [1:0] id, bit cv, logic [1:0] cc,
                                           bit rj, bit se, int cr, bit bz);
    return {d, id, cv, cc, rj, se, cr[4:0], bz};
  endfunction

  function automatic logic [13:0] actual();
    return {tb_if.dispense, tb_if.dispense_id, tb_if.change_valid, tb_if.change_coin,
            tb_if.coin_reject, tb_if.sel_error, tb_if.credit, tb_if.busy};
  endfunction

  function automatic vec_t row(bit ci, int coin, bit sv, int sel, bit can,
                               bit d, int id, bit cv, int cc, bit rj, bit se, int cr, bit bz);
    vec_t v;
    v.ci   = ci;
    v.coin = coin[1:0];
    v.sv   = sv;
    v.sel  = sel[1:0];
    v.can  = can;
    v.exp  = pack_out(d, id[1:0], cv, cc[1:0], rj, se, cr, bz);
    return v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_busy   = 1'b0;
    m_credit = 0;
  endtask

  // Owed amount paid out greedily in coins of at most 3, one queue entry per cycle.
  task automatic queue_payout(input int owed);
    int    rem;
    int    c;
    step_t s;
    rem = owed;
    while (rem > 0) begin
      c      = (rem > 3) ? 3 : rem;
      rem    = rem - c;
      s.d    = 1'b0;
      s.id   = 2'd0;
      s.cv   = 1'b1;
      s.cc   = c[1:0];
      s.credit = rem;
      m_q.push_back(s);
    end
  endtask

  task automatic model_step(input bit ci, input logic [1:0] code, input bit sv,
                            input logic [1:0] sel, input bit can);
    bit    coin_evt, rj, se;
    step_t s;
    coin_evt = ci && (code != 2'd0);
    rj = 1'b0;
    se = 1'b0;
    s.d = 1'b0; s.id = 2'd0; s.cv = 1'b0; s.cc = 2'd0; s.credit = 0;
    if (m_busy) begin
      rj = coin_evt;
    end else if (can) begin
      rj = coin_evt;
      if (m_credit > 0) queue_payout(m_credit);
    end else if (sv) begin
      rj = coin_evt;
      if (m_credit == 0 || m_credit < prices[sel]) begin
        se = 1'b1;
      end else begin
        s.d = 1'b1; s.id = sel; s.credit = m_credit;
        m_q.push_back(s);
        queue_payout(m_credit - prices[sel]);
      end
    end else if (coin_evt) begin
      if (m_credit + int'(code) <= 20) m_credit = m_credit + int'(code);
      else                             rj = 1'b1;
    end
    s.d = 1'b0; s.id = 2'd0; s.cv = 1'b0; s.cc = 2'd0;
    if (m_q.size() > 0) begin
      s        = m_q.pop_front();
      m_credit = s.credit;
      m_busy   = 1'b1;
    end else begin
      if (m_busy) m_credit = 0;
      m_busy = 1'b0;
    end
    m_exp = pack_out(s.d, s.id, s.cv, s.cc, rj, se, m_credit, m_busy);
  endtask

  task automatic checkOutput(input string name, input logic [13:0] exp);
    logic [13:0] act;
    act = actual();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b required %b (d id cv cc rj se credit busy)", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit ci, input logic [1:0] code, input bit sv,
                               input logic [1:0] sel, input bit can);
    tb_if.coin_inserted = ci;
    tb_if.coin_in       = code;
    tb_if.select_valid  = sv;
    tb_if.product_sel   = sel;
    tb_if.cancel        = can;
    @(posedge clk);
    model_step(ci, code, sv, sel, can);
    #1;
    tb_if.coin_inserted = 1'b0;
    tb_if.coin_in       = 2'd0;
    tb_if.select_valid  = 1'b0;
    tb_if.product_sel   = 2'd0;
    tb_if.cancel        = 1'b0;
  endtask

  initial begin
    reset               = 1'b0;
    tb_if.coin_inserted = 1'b0;
    tb_if.coin_in       = 2'd0;
    tb_if.select_valid  = 1'b0;
    tb_if.product_sel   = 2'd0;
    tb_if.cancel        = 1'b0;
    model_reset();

    // Prices: p0=5 p1=7 p2=8 p3=9; ceiling 20.
    // row(ci,coin,sv,sel,can, d,id,cv,cc,rj,se,credit,busy)
    tbl.push_back(row(0,0,1,1,0, 0,0,0,0,0,1, 0,0));
    tbl.push_back(row(1,0,0,0,0, 0,0,0,0,0,0, 0,0));
    tbl.push_back(row(1,2,0,0,1, 0,0,0,0,1,0, 0,0));
    tbl.push_back(row(1,2,0,0,0, 0,0,0,0,0,0, 2,0));
    tbl.push_back(row(1,3,0,0,0, 0,0,0,0,0,0, 5,0));
    tbl.push_back(row(1,2,0,0,0, 0,0,0,0,0,0, 7,0));
    tbl.push_back(row(0,0,1,2,0, 0,0,0,0,0,1, 7,0));
    tbl.push_back(row(0,0,1,1,0, 1,1,0,0,0,0, 7,1));
    tbl.push_back(row(0,0,0,0,0, 0,0,0,0,0,0, 0,0));
    tbl.push_back(row(1,3,0,0,0, 0,0,0,0,0,0, 3,0));
    tbl.push_back(row(1,3,0,0,0, 0,0,0,0,0,0, 6,0));
    tbl.push_back(row(1,2,0,0,0, 0,0,0,0,0,0, 8,0));
    tbl.push_back(row(0,0,1,1,0, 1,1,0,0,0,0, 8,1));
    tbl.push_back(row(0,0,0,0,0, 0,0,1,1,0,0, 0,1));
    tbl.push_back(row(0,0,0,0,0, 0,0,0,0,0,0, 0,0));
    tbl.push_back(row(1,3,0,0,0, 0,0,0,0,0,0, 3,0));
    tbl.push_back(row(1,3,0,0,0, 0,0,0,0,0,0, 6,0));
    tbl.push_back(row(1,3,0,0,0, 0,0,0,0,0,0, 9,0));
    tbl.push_back(row(1,3,0,0,0, 0,0,0,0,0,0,12,0));
    tbl.push_back(row(0,0,1,0,0, 1,0,0,0,0,0,12,1));
    tbl.push_back(row(0,0,0,0,1, 0,0,1,3,0,0, 4,1));
    tbl.push_back(row(0,0,1,0,0, 0,0,1,3,0,0, 1,1));
    tbl.push_back(row(0,0,0,0,0, 0,0,1,1,0,0, 0,1));
    tbl.push_back(row(0,0,0,0,0, 0,0,0,0,0,0, 0,0));
    tbl.push_back(row(1,3,0,0,0, 0,0,0,0,0,0, 3,0));
    tbl.push_back(row(1,2,0,0,0, 0,0,0,0,0,0, 5,0));
    tbl.push_back(row(0,0,1,3,0, 0,0,0,0,0,1, 5,0));
    tbl.push_back(row(0,0,0,0,1, 0,0,1,3,0,0, 2,1));
    tbl.push_back(row(0,0,0,0,0, 0,0,1,2,0,0, 0,1));
    tbl.push_back(row(0,0,0,0,0, 0,0,0,0,0,0, 0,0));
    for (int k = 1; k <= 6; k++) tbl.push_back(row(1,3,0,0,0, 0,0,0,0,0,0, 3*k,0));
    tbl.push_back(row(1,1,0,0,0, 0,0,0,0,0,0,19,0));
    tbl.push_back(row(1,3,0,0,0, 0,0,0,0,1,0,19,0));
    tbl.push_back(row(1,1,0,0,0, 0,0,0,0,0,0,20,0));
    tbl.push_back(row(1,1,0,0,0, 0,0,0,0,1,0,20,0));
    tbl.push_back(row(0,0,0,0,1, 0,0,1,3,0,0,17,1));
    tbl.push_back(row(1,2,0,0,0, 0,0,1,3,1,0,14,1));
    tbl.push_back(row(0,0,0,0,0, 0,0,1,3,0,0,11,1));
    tbl.push_back(row(0,0,0,0,0, 0,0,1,3,0,0, 8,1));
    tbl.push_back(row(0,0,0,0,0, 0,0,1,3,0,0, 5,1));
    tbl.push_back(row(0,0,0,0,0, 0,0,1,3,0,0, 2,1));
    tbl.push_back(row(0,0,0,0,0, 0,0,1,2,0,0, 0,1));
    tbl.push_back(row(0,0,0,0,0, 0,0,0,0,0,0, 0,0));
    tbl.push_back(row(1,3,0,0,0, 0,0,0,0,0,0, 3,0));
    tbl.push_back(row(1,3,0,0,0, 0,0,0,0,0,0, 6,0));
    tbl.push_back(row(1,3,1,1,0, 0,0,0,0,1,1, 6,0));
    tbl.push_back(row(1,2,1,0,0, 1,0,0,0,1,0, 6,1));
    tbl.push_back(row(0,0,0,0,0, 0,0,1,1,0,0, 0,1));
    tbl.push_back(row(0,0,0,0,0, 0,0,0,0,0,0, 0,0));
    tbl.push_back(row(1,2,0,0,0, 0,0,0,0,0,0, 2,0));
    tbl.push_back(row(1,3,0,0,1, 0,0,1,2,1,0, 0,1));
    tbl.push_back(row(0,0,0,0,0, 0,0,0,0,0,0, 0,0));

    #1;
    checkOutput("reset_outputs", 14'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    checkOutput("reset_release", 14'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].ci, tbl[i].coin, tbl[i].sv, tbl[i].sel, tbl[i].can);
      checkOutput($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Reset asserted in the middle of a payout must clear everything without a clock edge.
    applyStimulus(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
    checkOutput("pre_reset_credit", pack_out(0, 2'd0, 0, 2'd0, 0, 0, 9, 0));
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    checkOutput("pre_reset_change", pack_out(0, 2'd0, 1, 2'd3, 0, 0, 6, 1));
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset", 14'd0);
    model_reset();
    @(posedge clk);
    #1;
    checkOutput("reset_hold", 14'd0);
    reset = 1'b1;
    applyStimulus(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
    checkOutput("post_reset_coin", pack_out(0, 2'd0, 0, 2'd0, 0, 0, 2, 0));
    applyStimulus(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
    checkOutput("post_reset_collect", pack_out(0, 2'd0, 0, 2'd0, 0, 0, 5, 0));
    applyStimulus(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
    checkOutput("post_reset_vend", pack_out(1, 2'd0, 0, 2'd0, 0, 0, 5, 1));
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    checkOutput("post_reset_idle", 14'd0);

    for (int n = 0; n < 3000; n++) begin
      bit         ci, sv, can;
      logic [1:0] code, sel;
      ci   = ($urandom_range(0, 9) < 4);
      code = 2'($urandom_range(0, 3));
      sv   = ($urandom_range(0, 9) < 2);
      sel  = 2'($urandom_range(0, 3));
      can  = ($urandom_range(0, 29) == 0);
      applyStimulus(ci, code, sv, sel, can);
      checkOutput($sformatf("random%0d", n), m_exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
